axi_frame_stream_tx: RTL and testbench
======================================

Name: axi_frame_stream_tx

Overview:
- AXI4-Stream master that sends pixel-group frames to the image-processor farm; the stream-frontend controller consumes this stream.
- Accepts pixel groups from a frame source over a valid/ready port and frames them into packets of FRAME_PG_NUM beats.
- Asserts tlast on the last beat of each frame and routes each frame to the next processor round-robin via tdest.
- Registered 2-entry skid output, so full throughput with no combinational ready path to the sink.

Parameters:
IP_AMT, 1, number of image processors (tdest round-robin modulus)
IP_ADDR_W, $clog2(IP_AMT), processor index width
AXIS_TID_W, 2, tid width
AXIS_TID_VAL, 0, constant tid driven on every beat
AXIS_TDEST_W, (IP_ADDR_W>1)?IP_ADDR_W:1, tdest width
AXIS_TDATA_W, 256, data width (one pixel group)
AXIS_TKEEP_W, AXIS_TDATA_W/8, tkeep width
AXIS_TSTRB_W, AXIS_TDATA_W/8, tstrb width
FRAME_PG_NUM, 2400, pixel groups per frame (240 rows x 10 groups)
PG_CNT_W, $clog2(FRAME_PG_NUM), beat counter width

Ports:
s_aclk  in  1  clock
s_aresetn  in  1  asynchronous active-low reset
en_i  in  1  streaming enable, sampled only at frame boundaries
pgroup_i  in  AXIS_TDATA_W  pixel group from frame source
pgroup_valid_i  in  1  pixel group valid
pgroup_ready_o  out  1  pixel group accepted when valid&ready
m_tid_o  out  AXIS_TID_W  constant AXIS_TID_VAL
m_tdest_o  out  AXIS_TDEST_W  target processor of current frame
m_tdata_o  out  AXIS_TDATA_W  pixel group
m_tkeep_o  out  AXIS_TKEEP_W  all ones
m_tstrb_o  out  AXIS_TSTRB_W  all ones
m_tlast_o  out  1  last beat of frame
m_tvalid_o  out  1  beat valid
m_tready_i  in  1  downstream ready
frame_done_o  out  1  1-cycle pulse when a tlast beat handshakes

Behaviour:
- Reset (async, s_aresetn=0): state=IDLE, beat_cnt=0, dest_idx=0, skid empty, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, m_tdest_o=0, pgroup_ready_o=0, frame_done_o=0. Reset mid-frame drops all buffered beats; no tlast is emitted for the partial frame.
- FSM IDLE: pgroup_ready_o=0. Move to STREAM when en_i=1.
- FSM STREAM: pgroup_ready_o = ~skid_full. Each accepted input increments beat_cnt. The beat is tagged last when beat_cnt==FRAME_PG_NUM-1; beat_cnt then wraps to 0.
- After the last beat is accepted: dest_idx = (dest_idx==IP_AMT-1) ? 0 : dest_idx+1. If en_i=0 in the accept cycle, go to IDLE; otherwise stay in STREAM.
- IP_AMT=1: tdest is always 0.
- Each beat's tdest is latched with its data, so a dest change never alters beats already buffered.
- Skid buffer: output register plus one spare entry. Latency from input handshake to m_tvalid_o is 1 cycle.
- AXIS rule: once m_tvalid_o=1, tdata/tlast/tdest hold stable until m_tready_i=1. tvalid never drops without a handshake.
- Simultaneous input accept and output handshake keeps occupancy constant.
- Throughput: 1 beat/cycle with m_tready_i held high.
- Stall: m_tready_i=0 for two or more cycles fills both entries, then pgroup_ready_o=0 on the next cycle.
- frame_done_o pulses in the cycle after the tlast handshake.
- Buffered beats drain in IDLE. en_i has no effect on the output side.

Optional Feature:
Macro AXIS_TX_SOF_CHK_EN.
- Defined:
  - Adds input pgroup_sof_i (1 bit) and output frame_err_o (1 bit, sticky, reset 0).
  - An accepted beat with pgroup_sof_i=1 while beat_cnt!=0 sets frame_err_o. dest_idx advances and the beat becomes beat 0 of the new frame (beat_cnt=1 after accept).
  - The truncated frame has no tlast.
  - An accepted beat with beat_cnt==0 and pgroup_sof_i=0 also sets frame_err_o, but framing is unchanged.
  - frame_err_o clears only on reset.
- Undefined: neither port exists. Framing is by beat count only.

Test Plan:
- Bench params FRAME_PG_NUM=4, IP_AMT=3, en_i=1, input always valid, m_tready_i=1 -> beats 1 cycle after accept; tlast on beats 3, 7, 11; tdest 0,0,0,0,1,1,1,1,2,2,2,2 then 0; frame_done_o pulses 3 times.
- m_tready_i=0 for 5 cycles mid-frame -> tdata/tlast/tdest stable, pgroup_ready_o=0 after 2 buffered beats, no beat lost or duplicated (data sequence 0x1..0xC intact).
- en_i dropped at beat 1 of frame 0 -> frame 0 completes with tlast on beat 3, then state IDLE and pgroup_ready_o=0; re-raise en_i -> next frame has tdest=1.
- Async reset at beat 2 of a frame -> all outputs 0 immediately; after release, first frame has tdest=0 and tlast on its 4th beat.
- IP_AMT=1 -> tdest=0 on every beat; tkeep/tstrb=all ones; tid=AXIS_TID_VAL.
- AXIS_TX_SOF_CHK_EN defined, sof on beat 2 -> frame_err_o=1; that beat tagged tdest=1 and tlast on 3 beats later.

Source files
------------

// File: rtl/axi_frame_stream_tx_if.sv
// AXI4-Stream bus carrying framed pixel groups from axi_frame_stream_tx to the stream frontend.
interface axi_frame_stream_tx_if #(
   parameter int unsigned TID_W   = 2,
   parameter int unsigned TDEST_W = 1,
   parameter int unsigned TDATA_W = 256
);
   localparam int unsigned TKEEP_W = TDATA_W / 8;

   logic [TID_W-1:0]   tid;
   logic [TDEST_W-1:0] tdest;
   logic [TDATA_W-1:0] tdata;
   logic [TKEEP_W-1:0] tkeep;
   logic [TKEEP_W-1:0] tstrb;
   logic               tlast;
   logic               tvalid;
   logic               tready;

   modport master (
      output tid, tdest, tdata, tkeep, tstrb, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tid, tdest, tdata, tkeep, tstrb, tlast, tvalid,
      output tready
   );
endinterface

// File: rtl/axi_frame_stream_tx.sv
// Frames pixel groups into FRAME_PG_NUM-beat AXI4-Stream packets with round-robin tdest.
// Optional start-of-frame checking is enabled by defining AXIS_TX_SOF_CHK_EN.
module axi_frame_stream_tx #(
   parameter int unsigned IP_AMT       = 1,
   parameter int unsigned IP_ADDR_W    = $clog2(IP_AMT),
   parameter int unsigned AXIS_TID_W   = 2,
   parameter int unsigned AXIS_TID_VAL = 0,
   parameter int unsigned AXIS_TDEST_W = (IP_ADDR_W > 1) ? IP_ADDR_W : 1,
   parameter int unsigned AXIS_TDATA_W = 256,
   parameter int unsigned AXIS_TKEEP_W = AXIS_TDATA_W / 8,
   parameter int unsigned AXIS_TSTRB_W = AXIS_TDATA_W / 8,
   parameter int unsigned FRAME_PG_NUM = 2400,
   parameter int unsigned PG_CNT_W     = $clog2(FRAME_PG_NUM)
) (
   input  logic                    s_aclk,
   input  logic                    s_aresetn,
   input  logic                    en_i,
   input  logic [AXIS_TDATA_W-1:0] pgroup_i,
   input  logic                    pgroup_valid_i,
   output logic                    pgroup_ready_o,
`ifdef AXIS_TX_SOF_CHK_EN
   input  logic                    pgroup_sof_i,
   output logic                    frame_err_o,
`endif
   output logic                    frame_done_o,
   axi_frame_stream_tx_if.master   m_axis
);

   localparam int unsigned CNT_W = (PG_CNT_W > 0) ? PG_CNT_W : 1;
   localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(FRAME_PG_NUM - 1);
   localparam logic [AXIS_TDEST_W-1:0] LAST_DEST = AXIS_TDEST_W'(IP_AMT - 1);

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [AXIS_TDEST_W-1:0] dest_idx_q, dest_idx_d;
   logic                    ready_q, ready_d;
   logic                    frame_done_q, frame_done_d;

   // Output register (what the sink sees) and the spare entry behind it.
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic [AXIS_TDEST_W-1:0] out_dest_q, out_dest_d;
   logic [AXIS_TDATA_W-1:0] out_data_q, out_data_d;
   logic                    sp_valid_q, sp_valid_d;
   logic                    sp_last_q, sp_last_d;
   logic [AXIS_TDEST_W-1:0] sp_dest_q, sp_dest_d;
   logic [AXIS_TDATA_W-1:0] sp_data_q, sp_data_d;

   logic                    in_acc, out_hs, in_last, restart;
   logic [AXIS_TDEST_W-1:0] in_dest, next_dest;

`ifdef AXIS_TX_SOF_CHK_EN
   logic frame_err_q, frame_err_d;
`endif

   always_comb begin
      in_acc    = pgroup_valid_i & ready_q;
      out_hs    = out_valid_q & m_axis.tready;
      next_dest = (dest_idx_q == LAST_DEST) ? '0 : dest_idx_q + AXIS_TDEST_W'(1);
`ifdef AXIS_TX_SOF_CHK_EN
      // A mid-frame sof abandons the current frame and opens a new one on this beat.
      restart     = pgroup_sof_i & (beat_cnt_q != '0);
      frame_err_d = frame_err_q | (in_acc & (pgroup_sof_i ^ (beat_cnt_q == '0)));
`else
      restart     = 1'b0;
`endif
      in_dest = restart ? next_dest : dest_idx_q;
      in_last = ~restart & (beat_cnt_q == LAST_CNT);

      beat_cnt_d = beat_cnt_q;
      dest_idx_d = dest_idx_q;
      state_d    = state_q;
      if (in_acc) begin
         if (restart) begin
            beat_cnt_d = CNT_W'(1);
            dest_idx_d = next_dest;
         end else if (in_last) begin
            beat_cnt_d = '0;
            dest_idx_d = next_dest;
         end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
         end
      end

      unique case (state_q)
         StIdle:   if (en_i) state_d = StStream;
         StStream: if (in_acc && in_last && !en_i) state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_dest_d  = out_dest_q;
      out_data_d  = out_data_q;
      sp_valid_d  = sp_valid_q;
      sp_last_d   = sp_last_q;
      sp_dest_d   = sp_dest_q;
      sp_data_d   = sp_data_q;
      if (out_hs || !out_valid_q) begin
         if (sp_valid_q) begin
            // Input cannot be accepted while the spare is full, so only the spare moves.
            out_valid_d = 1'b1;
            out_last_d  = sp_last_q;
            out_dest_d  = sp_dest_q;
            out_data_d  = sp_data_q;
            sp_valid_d  = 1'b0;
         end else if (in_acc) begin
            out_valid_d = 1'b1;
            out_last_d  = in_last;
            out_dest_d  = in_dest;
            out_data_d  = pgroup_i;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_acc) begin
         sp_valid_d = 1'b1;
         sp_last_d  = in_last;
         sp_dest_d  = in_dest;
         sp_data_d  = pgroup_i;
      end

      ready_d      = (state_d == StStream) & ~sp_valid_d;
      frame_done_d = out_hs & out_last_q;
   end

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         state_q      <= StIdle;
         beat_cnt_q   <= '0;
         dest_idx_q   <= '0;
         ready_q      <= 1'b0;
         frame_done_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_dest_q   <= '0;
         out_data_q   <= '0;
         sp_valid_q   <= 1'b0;
         sp_last_q    <= 1'b0;
         sp_dest_q    <= '0;
         sp_data_q    <= '0;
`ifdef AXIS_TX_SOF_CHK_EN
         frame_err_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         dest_idx_q   <= dest_idx_d;
         ready_q      <= ready_d;
         frame_done_q <= frame_done_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_dest_q   <= out_dest_d;
         out_data_q   <= out_data_d;
         sp_valid_q   <= sp_valid_d;
         sp_last_q    <= sp_last_d;
         sp_dest_q    <= sp_dest_d;
         sp_data_q    <= sp_data_d;
`ifdef AXIS_TX_SOF_CHK_EN
         frame_err_q  <= frame_err_d;
`endif
      end
   end

   assign pgroup_ready_o = ready_q;
   assign frame_done_o   = frame_done_q;
`ifdef AXIS_TX_SOF_CHK_EN
   assign frame_err_o    = frame_err_q;
`endif

   assign m_axis.tid    = AXIS_TID_W'(AXIS_TID_VAL);
   assign m_axis.tdest  = out_dest_q;
   assign m_axis.tdata  = out_data_q;
   assign m_axis.tkeep  = {AXIS_TKEEP_W{1'b1}};
   assign m_axis.tstrb  = {AXIS_TSTRB_W{1'b1}};
   assign m_axis.tlast  = out_last_q;
   assign m_axis.tvalid = out_valid_q;

endmodule

// File: tb/tb_axi_frame_stream_tx.sv
// Scoreboard bench: a 3-processor and a 1-processor instance (4-beat frames) share one stimulus.
`timescale 1ns/1ps
module tb_axi_frame_stream_tx;
   localparam int DW    = 32;
   localparam int FPG   = 4;
   localparam int TIDV3 = 1;
   localparam int TIDV1 = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [1:0]    dest;
   } beat_t;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          en     = 1'b0;
   logic [DW-1:0] pgroup = '0;
   logic          pvalid = 1'b0;
   logic          tready = 1'b1;
   logic          rdy3, rdy1, fd3, fd1;
`ifdef AXIS_TX_SOF_CHK_EN
   logic          sof    = 1'b0;
   logic          err3, err1;
`endif

   always #5 clk = ~clk;

   axi_frame_stream_tx_if #(.TID_W(2), .TDEST_W(2), .TDATA_W(DW)) ax3 ();
   axi_frame_stream_tx_if #(.TID_W(2), .TDEST_W(1), .TDATA_W(DW)) ax1 ();
   assign ax3.tready = tready;
   assign ax1.tready = tready;

   axi_frame_stream_tx #(
      .IP_AMT(3), .AXIS_TID_VAL(TIDV3), .AXIS_TDATA_W(DW), .FRAME_PG_NUM(FPG)
   ) dut3 (
      .s_aclk(clk), .s_aresetn(rst_n), .en_i(en), .pgroup_i(pgroup),
      .pgroup_valid_i(pvalid), .pgroup_ready_o(rdy3),
`ifdef AXIS_TX_SOF_CHK_EN
      .pgroup_sof_i(sof), .frame_err_o(err3),
`endif
      .frame_done_o(fd3), .m_axis(ax3)
   );

   axi_frame_stream_tx #(
      .IP_AMT(1), .AXIS_TID_VAL(TIDV1), .AXIS_TDATA_W(DW), .FRAME_PG_NUM(FPG)
   ) dut1 (
      .s_aclk(clk), .s_aresetn(rst_n), .en_i(en), .pgroup_i(pgroup),
      .pgroup_valid_i(pvalid), .pgroup_ready_o(rdy1),
`ifdef AXIS_TX_SOF_CHK_EN
      .pgroup_sof_i(sof), .frame_err_o(err1),
`endif
      .frame_done_o(fd1), .m_axis(ax1)
   );

   logic [DW-1:0] m_data  [2];
   logic [1:0]    m_dest  [2];
   logic [1:0]    m_tid   [2];
   logic [3:0]    m_keep  [2];
   logic [3:0]    m_strb  [2];
   logic          m_valid [2];
   logic          m_last  [2];
   logic          m_fd    [2];
   logic          m_rdy   [2];
   assign m_data[0] = ax3.tdata;   assign m_data[1] = ax1.tdata;
   assign m_dest[0] = ax3.tdest;   assign m_dest[1] = {1'b0, ax1.tdest};
   assign m_tid[0]  = ax3.tid;     assign m_tid[1]  = ax1.tid;
   assign m_keep[0] = ax3.tkeep;   assign m_keep[1] = ax1.tkeep;
   assign m_strb[0] = ax3.tstrb;   assign m_strb[1] = ax1.tstrb;
   assign m_valid[0] = ax3.tvalid; assign m_valid[1] = ax1.tvalid;
   assign m_last[0] = ax3.tlast;   assign m_last[1] = ax1.tlast;
   assign m_fd[0]   = fd3;         assign m_fd[1]   = fd1;
   assign m_rdy[0]  = rdy3;        assign m_rdy[1]  = rdy1;

   int    vec = 0;
   int    bad = 0;
   int    cyc = 0;
   beat_t q0[$];
   beat_t q1[$];
   int    hs_cnt[2];
   int    fd_cnt[2];
   int    first_valid_cyc[2];
   int    first_acc_cyc = -1;
   logic  hold[2];
   beat_t held[2];
   logic  fd_pend[2];

   // Reference framing model
   int    pos = 0;
   int    dest[2];
   int    data_cnt = 1;
   logic  err_exp = 1'b0;
   logic  force_sof = 1'b0;

   always @(negedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_push();
      beat_t b;
      logic  last;
`ifdef AXIS_TX_SOF_CHK_EN
      if (sof && pos != 0) begin
         err_exp = 1'b1;
         dest[0] = (dest[0] + 1) % 3;
         dest[1] = 0;
         pos = 0;
      end else if (!sof && pos == 0) begin
         err_exp = 1'b1;
      end
`endif
      last   = (pos == FPG - 1);
      b.data = DW'(data_cnt);
      b.last = last;
      b.dest = 2'(dest[0]);
      q0.push_back(b);
      b.dest = 2'(dest[1]);
      q1.push_back(b);
      if (last) begin
         pos = 0;
         dest[0] = (dest[0] + 1) % 3;
         dest[1] = 0;
      end else begin
         pos++;
      end
   endtask

   // One cycle of input drive; acceptance is known before the edge since ready is registered.
   task automatic step(output logic acc);
      @(negedge clk);
      pgroup = DW'(data_cnt);
`ifdef AXIS_TX_SOF_CHK_EN
      sof = force_sof | (pos == 0);
`endif
      #1;
      acc = pvalid && rdy3;
      if (acc) begin
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
         model_push();
         data_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beats(input int n, output int cycles);
      logic acc;
      int   got = 0;
      cycles = 0;
      while (got < n && cycles < 50) begin
         step(acc);
         cycles++;
         if (acc) got++;
      end
      if (got < n) begin
         vec++;
         bad++;
         $display("FAIL drive_timeout: got %0d beats accepted, expected %0d", got, n);
      end
   endtask

   task automatic drive_cycles(input int n, output int got);
      logic acc;
      got = 0;
      for (int i = 0; i < n; i++) begin
         step(acc);
         if (acc) got++;
      end
   endtask

   task automatic wait_drain();
      int c = 0;
      while ((q0.size() != 0 || q1.size() != 0) && c < 40) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      chk("drain_q0", 64'(q0.size()), 64'd0);
      chk("drain_q1", 64'(q1.size()), 64'd0);
`ifdef AXIS_TX_SOF_CHK_EN
      chk("frame_err3", 64'(err3), 64'(err_exp));
      chk("frame_err1", 64'(err1), 64'(err_exp));
`endif
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      en = 1'b0;
      pvalid = 1'b0;
      tready = 1'b1;
      force_sof = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_tvalid", 64'(m_valid[k]), 64'd0);
         chk("rst_tlast", 64'(m_last[k]), 64'd0);
         chk("rst_tdata", 64'(m_data[k]), 64'd0);
         chk("rst_tdest", 64'(m_dest[k]), 64'd0);
         chk("rst_ready", 64'(m_rdy[k]), 64'd0);
         chk("rst_frame_done", 64'(m_fd[k]), 64'd0);
      end
`ifdef AXIS_TX_SOF_CHK_EN
      chk("rst_frame_err", 64'({err3, err1}), 64'd0);
`endif
      q0.delete();
      q1.delete();
      pos = 0;
      dest[0] = 0;
      dest[1] = 0;
      err_exp = 1'b0;
      data_cnt = 1;
      first_acc_cyc = -1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: samples 2ns after the falling edge, ahead of the handshake edge.
   initial begin
      beat_t e;
      beat_t cur;
      logic  empty;
      logic [1:0] exp_tid;
      for (int k = 0; k < 2; k++) begin
         hs_cnt[k] = 0;
         fd_cnt[k] = 0;
      end
      forever begin
         @(negedge clk);
         #2;
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               hold[k] = 1'b0;
               fd_pend[k] = 1'b0;
               first_valid_cyc[k] = -1;
            end else begin
               cur.data = m_data[k];
               cur.last = m_last[k];
               cur.dest = m_dest[k];
               if (fd_pend[k] || m_fd[k]) chk("frame_done", 64'(m_fd[k]), 64'(fd_pend[k]));
               if (m_fd[k]) fd_cnt[k]++;
               fd_pend[k] = 1'b0;
               if (hold[k]) begin
                  chk("hold_tvalid", 64'(m_valid[k]), 64'd1);
                  chk("hold_beat", 64'(cur), 64'(held[k]));
                  hold[k] = 1'b0;
               end
               if (m_valid[k]) begin
                  if (first_valid_cyc[k] < 0) first_valid_cyc[k] = cyc;
                  if (tready) begin
                     empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                     if (empty) begin
                        vec++;
                        bad++;
                        $display("FAIL unexpected_beat dut%0d: got 0x%0h, expected no beat",
                                 k, cur);
                     end else begin
                        if (k == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        exp_tid = (k == 0) ? 2'(TIDV3) : 2'(TIDV1);
                        chk("beat{data,last,dest}", 64'(cur), 64'(e));
                        chk("sideband{tid,keep,strb}", 64'({m_tid[k], m_keep[k], m_strb[k]}),
                            64'({exp_tid, 4'hF, 4'hF}));
                        hs_cnt[k]++;
                        fd_pend[k] = m_last[k];
                     end
                  end else begin
                     hold[k] = 1'b1;
                     held[k] = cur;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1);
   end

   initial begin
      int cycles;
      int got;
      int hs0, hs1, fd0, fdc1;

      // Streaming at full rate: tlast on beats 4,8,12, tdest 0/1/2 then 0.
      apply_reset();
      chk("idle_ready", 64'(rdy3), 64'd0);
      en = 1'b1;
      pvalid = 1'b1;
      drive_beats(13, cycles);
      pvalid = 1'b0;
      chk("throughput_cycles", 64'(cycles), 64'd13);
      wait_drain();
      chk("latency", 64'(first_valid_cyc[0] - first_acc_cyc), 64'd1);
      chk("hs_count3", 64'(hs_cnt[0]), 64'd13);
      chk("hs_count1", 64'(hs_cnt[1]), 64'd13);
      chk("frame_done_count3", 64'(fd_cnt[0]), 64'd3);
      chk("frame_done_count1", 64'(fd_cnt[1]), 64'd3);

      // Downstream stall mid-frame: both entries fill, ready drops, no beat lost.
      apply_reset();
      hs0 = hs_cnt[0];
      en = 1'b1;
      pvalid = 1'b1;
      drive_beats(5, cycles);
      tready = 1'b0;
      drive_cycles(5, got);
      chk("stall_accepts", 64'(got), 64'd1);
      chk("stall_ready", 64'(rdy3), 64'd0);
      tready = 1'b1;
      drive_beats(6, cycles);
      pvalid = 1'b0;
      wait_drain();
      chk("stall_hs_count", 64'(hs_cnt[0] - hs0), 64'd12);

      // en dropped at beat 1: frame completes, goes idle, next frame targets processor 1.
      apply_reset();
      fd0 = fd_cnt[0];
      en = 1'b1;
      pvalid = 1'b1;
      drive_beats(2, cycles);
      en = 1'b0;
      drive_cycles(6, got);
      chk("en_drop_accepts", 64'(got), 64'd2);
      chk("en_drop_ready", 64'(rdy3), 64'd0);
      en = 1'b1;
      drive_beats(4, cycles);
      pvalid = 1'b0;
      wait_drain();
      chk("en_drop_frame_done", 64'(fd_cnt[0] - fd0), 64'd2);

      // Reset at beat 2 drops the partial frame; the next frame restarts at tdest 0.
      apply_reset();
      en = 1'b1;
      pvalid = 1'b1;
      drive_beats(3, cycles);
      apply_reset();
      hs1 = hs_cnt[1];
      fdc1 = fd_cnt[1];
      en = 1'b1;
      pvalid = 1'b1;
      drive_beats(4, cycles);
      pvalid = 1'b0;
      wait_drain();
      chk("post_reset_hs1", 64'(hs_cnt[1] - hs1), 64'd4);
      chk("post_reset_frame_done1", 64'(fd_cnt[1] - fdc1), 64'd1);

`ifdef AXIS_TX_SOF_CHK_EN
      // sof on beat 2 restarts framing on tdest 1 and raises the sticky error.
      apply_reset();
      en = 1'b1;
      pvalid = 1'b1;
      drive_beats(2, cycles);
      chk("sof_err_before", 64'(err3), 64'd0);
      force_sof = 1'b1;
      drive_beats(1, cycles);
      force_sof = 1'b0;
      drive_beats(3, cycles);
      pvalid = 1'b0;
      wait_drain();
      chk("sof_err_after", 64'(err3), 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
